alu_unit: RTL and testbench

Single-cycle-registered execute unit for the 16-bit processor.
- Takes decoded operands (rs_data, rt_data, rd_load, shamt, constant, address) and a 4-bit opcode.
- Produces the register writeback value, HI/LO registers, a 32-bit product and the next PC.
- Contains a 256x16 data memory for load/store, and sits between the register-file read stage and writeback.

---
 rtl/alu_if.sv | 34 +++
 rtl/alu_unit.sv | 190 +++++++++++++++++++
 tb/tb_alu_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand, control and result bundle between the decode stage and the execute unit.
interface alu_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
);
    logic [3:0]      opcode;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic [DW-1:0]   rd_load;
    logic [2:0]      shamt;
    logic [5:0]      constant;
    logic [AW-1:0]   address;
    logic [AW-1:0]   pc;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   hi_out;
    logic [DW-1:0]   lo_out;
    logic [2*DW-1:0] TEMP;
    logic [AW-1:0]   pc_1;

    modport master (
        output opcode, rs_data, rt_data, rd_load, shamt, constant, address, pc,
        output reg_write, mem_read, mem_write,
        input  rd_data, hi_out, lo_out, TEMP, pc_1
    );

    modport slave (
        input  opcode, rs_data, rt_data, rd_load, shamt, constant, address, pc,
        input  reg_write, mem_read, mem_write,
        output rd_data, hi_out, lo_out, TEMP, pc_1
    );
endinterface

// File: rtl/alu_unit.sv
// Execute stage of the 16-bit processor: ALU, multiply/divide into HI/LO/TEMP,
// a word-addressed data memory for LW/SW and next-PC selection, all registered.
module alu_unit #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpSub  = 4'h1,
        OpAnd  = 4'h2,
        OpOr   = 4'h3,
        OpXor  = 4'h4,
        OpSll  = 4'h5,
        OpSrl  = 4'h6,
        OpAddi = 4'h7,
        OpMul  = 4'h8,
        OpDiv  = 4'h9,
        OpLw   = 4'hA,
        OpSw   = 4'hB,
        OpBeq  = 4'hC,
        OpBne  = 4'hD,
        OpJ    = 4'hE,
        OpSlt  = 4'hF
    } op_e;

    op_e op;
    assign op = op_e'(bus.opcode);

    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic [2*DW-1:0] temp_q, temp_d;
    logic [AW-1:0]   pc_q, pc_d;

    logic [DW-1:0]   imm_ext;
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   br_target;
    logic [2*DW-1:0] product;
    logic            div_zero;
    logic [DW-1:0]   divisor;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            slt;
    logic [DW-1:0]   mem_rdata;
    logic [DW-1:0]   alu_res;
    logic            writes_reg;
    logic            mem_we;

    assign imm_ext   = {{(DW-6){bus.constant[5]}}, bus.constant};
    assign pc_inc    = bus.pc + AW'(1);
    assign br_target = pc_inc + imm_ext[AW-1:0];
    assign product   = (2*DW)'(bus.rs_data) * (2*DW)'(bus.rt_data);

    // Divide-by-zero yields all-ones quotient and passes the dividend through as remainder.
    assign div_zero  = (bus.rt_data == '0);
    assign divisor   = div_zero ? DW'(1) : bus.rt_data;
    assign quotient  = div_zero ? '1 : (bus.rs_data / divisor);
    assign remainder = div_zero ? bus.rs_data : (bus.rs_data % divisor);

    assign slt       = ($signed(bus.rs_data) < $signed(bus.rt_data));
    assign mem_rdata = mem[bus.address];
    assign mem_we    = (op == OpSw) && bus.mem_write;

    always_comb begin
        alu_res    = '0;
        writes_reg = 1'b0;
        unique case (op)
            OpAdd: begin
                alu_res    = bus.rs_data + bus.rt_data;
                writes_reg = 1'b1;
            end
            OpSub: begin
                alu_res    = bus.rs_data - bus.rt_data;
                writes_reg = 1'b1;
            end
            OpAnd: begin
                alu_res    = bus.rs_data & bus.rt_data;
                writes_reg = 1'b1;
            end
            OpOr: begin
                alu_res    = bus.rs_data | bus.rt_data;
                writes_reg = 1'b1;
            end
            OpXor: begin
                alu_res    = bus.rs_data ^ bus.rt_data;
                writes_reg = 1'b1;
            end
            OpSll: begin
                alu_res    = bus.rt_data << bus.shamt;
                writes_reg = 1'b1;
            end
            OpSrl: begin
                alu_res    = bus.rt_data >> bus.shamt;
                writes_reg = 1'b1;
            end
            OpAddi: begin
                alu_res    = bus.rs_data + imm_ext;
                writes_reg = 1'b1;
            end
            OpDiv: begin
                alu_res    = quotient;
                writes_reg = 1'b1;
            end
            OpLw: begin
                alu_res    = mem_rdata;
                writes_reg = bus.mem_read;
            end
            OpSlt: begin
                alu_res    = {{(DW-1){1'b0}}, slt};
                writes_reg = 1'b1;
            end
            default: begin
                alu_res    = '0;
                writes_reg = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_d   = rd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        temp_d = temp_q;
        pc_d   = pc_inc;

        if (bus.reg_write && writes_reg) begin
            rd_d = alu_res;
        end

        case (op)
            OpMul: begin
                temp_d = product;
                hi_d   = product[2*DW-1:DW];
                lo_d   = product[DW-1:0];
            end
            OpDiv: begin
                hi_d = remainder;
                lo_d = quotient;
            end
            OpBeq: begin
                if (bus.rs_data == bus.rt_data) pc_d = br_target;
            end
            OpBne: begin
                if (bus.rs_data != bus.rt_data) pc_d = br_target;
            end
            OpJ: begin
                pc_d = bus.address;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            temp_q <= '0;
            pc_q   <= '0;
        end else begin
            rd_q   <= rd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            temp_q <= temp_d;
            pc_q   <= pc_d;
        end
    end

    // Storage is never cleared; reset only blocks a coincident store.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[bus.address] <= bus.rd_load;
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.hi_out  = hi_q;
    assign bus.lo_out  = lo_q;
    assign bus.TEMP    = temp_q;
    assign bus.pc_1    = pc_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: stimulus pushes hand-computed results into a
// scoreboard queue and an independent monitor compares them one cycle later.
module tb_alu_unit;

    localparam logic [3:0] ADD  = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_  = 4'h3;
    localparam logic [3:0] XOR_ = 4'h4, SLL = 4'h5, SRL  = 4'h6, ADDI = 4'h7;
    localparam logic [3:0] MUL  = 4'h8, DIV = 4'h9, LW   = 4'hA, SW   = 4'hB;
    localparam logic [3:0] BEQ  = 4'hC, BNE = 4'hD, J    = 4'hE, SLT  = 4'hF;

    typedef struct {
        int          id;
        logic [15:0] rd;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [31:0] tmp;
        logic [7:0]  pc1;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_if bus ();

    alu_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          step = 0;
    bit          check_en = 1'b0;
    logic [15:0] e_rd, e_hi, e_lo;
    logic [31:0] e_tmp;

    task automatic chk(input int id, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s: got %h expected %h", id, what, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (check_en) begin
            exp_t e;
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: output cycle with no expectation queued");
            end else begin
                e = sb.pop_front();
                chk(e.id, "rd_data", {16'h0, bus.rd_data}, {16'h0, e.rd});
                chk(e.id, "hi_out",  {16'h0, bus.hi_out},  {16'h0, e.hi});
                chk(e.id, "lo_out",  {16'h0, bus.lo_out},  {16'h0, e.lo});
                chk(e.id, "TEMP",    bus.TEMP,             e.tmp);
                chk(e.id, "pc_1",    {24'h0, bus.pc_1},    {24'h0, e.pc1});
            end
        end
    end

    task automatic issue(input logic rst, input logic [3:0] opc,
                         input logic [15:0] rs, input logic [15:0] rt,
                         input logic [15:0] rdl, input logic [2:0] sh,
                         input logic [5:0] c, input logic [7:0] addr, input logic [7:0] pc,
                         input logic rw, input logic mr, input logic mw,
                         input logic [7:0] e_pc);
        exp_t e;
        rst_n          = rst;
        bus.opcode     = opc;
        bus.rs_data    = rs;
        bus.rt_data    = rt;
        bus.rd_load    = rdl;
        bus.shamt      = sh;
        bus.constant   = c;
        bus.address    = addr;
        bus.pc         = pc;
        bus.reg_write  = rw;
        bus.mem_read   = mr;
        bus.mem_write  = mw;
        step++;
        e.id  = step;
        e.rd  = e_rd;
        e.hi  = e_hi;
        e.lo  = e_lo;
        e.tmp = e_tmp;
        e.pc1 = e_pc;
        sb.push_back(e);
        check_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_rd = 16'h0; e_hi = 16'h0; e_lo = 16'h0; e_tmp = 32'h0;
        // Reset with live operands: everything must come up zero.
        issue(0, ADD, 16'h0041, 16'h0037, 16'h0, 3'd0, 6'd0, 8'h00, 8'h33, 1, 0, 0, 8'h00);

        e_rd = 16'h0078;
        issue(1, ADD, 16'h0041, 16'h0037, 16'h0, 3'd0, 6'd0, 8'h00, 8'h00, 1, 0, 0, 8'h01);
        e_rd = 16'hFFFF;
        issue(1, SUB, 16'h0001, 16'h0002, 16'h0, 3'd0, 6'd0, 8'h00, 8'h01, 1, 0, 0, 8'h02);
        issue(1, ADD, 16'h0005, 16'h0006, 16'h0, 3'd0, 6'd0, 8'h00, 8'h02, 0, 0, 0, 8'h03);

        e_tmp = 32'h0000E2C2; e_hi = 16'h0000; e_lo = 16'hE2C2;
        issue(1, MUL, 16'h01C2, 16'h0081, 16'h0, 3'd0, 6'd0, 8'h00, 8'h03, 1, 0, 0, 8'h04);
        e_tmp = 32'hFFFE0001; e_hi = 16'hFFFE; e_lo = 16'h0001;
        issue(1, MUL, 16'hFFFF, 16'hFFFF, 16'h0, 3'd0, 6'd0, 8'h00, 8'h04, 1, 0, 0, 8'h05);

        e_rd = 16'h000E; e_lo = 16'h000E; e_hi = 16'h0002;
        issue(1, DIV, 16'h0064, 16'h0007, 16'h0, 3'd0, 6'd0, 8'h00, 8'h05, 1, 0, 0, 8'h06);
        e_lo = 16'hFFFF; e_hi = 16'h1234;
        issue(1, DIV, 16'h1234, 16'h0000, 16'h0, 3'd0, 6'd0, 8'h00, 8'h06, 0, 0, 0, 8'h07);

        issue(1, SW,  16'h0, 16'h0, 16'hBEEF, 3'd0, 6'd0, 8'h10, 8'h07, 1, 1, 1, 8'h08);
        e_rd = 16'hBEEF;
        issue(1, LW,  16'h0, 16'h0, 16'h0,    3'd0, 6'd0, 8'h10, 8'h08, 1, 1, 0, 8'h09);
        issue(1, SW,  16'h0, 16'h0, 16'h1111, 3'd0, 6'd0, 8'h20, 8'h09, 0, 0, 1, 8'h0A);
        issue(1, LW,  16'h0, 16'h0, 16'h0,    3'd0, 6'd0, 8'h20, 8'h0A, 1, 0, 0, 8'h0B);
        issue(1, LW,  16'h0, 16'h0, 16'h0,    3'd0, 6'd0, 8'h20, 8'h0B, 0, 1, 0, 8'h0C);
        e_rd = 16'h1111;
        issue(1, LW,  16'h0, 16'h0, 16'h0,    3'd0, 6'd0, 8'h20, 8'h0C, 1, 1, 0, 8'h0D);
        issue(1, SW,  16'h0, 16'h0, 16'h5555, 3'd0, 6'd0, 8'h30, 8'h0D, 0, 0, 1, 8'h0E);
        issue(1, SW,  16'h0, 16'h0, 16'h7777, 3'd0, 6'd0, 8'h30, 8'h0E, 0, 0, 0, 8'h0F);
        issue(1, ADD, 16'h0, 16'h0, 16'h9999, 3'd0, 6'd0, 8'h30, 8'h0F, 0, 0, 1, 8'h10);

        issue(1, BEQ, 16'h0003, 16'h0003, 16'h0, 3'd0, 6'b111110, 8'h00, 8'h05, 0, 0, 0, 8'h04);
        issue(1, BNE, 16'h0003, 16'h0003, 16'h0, 3'd0, 6'b111110, 8'h00, 8'h05, 0, 0, 0, 8'h06);
        issue(1, BNE, 16'h0001, 16'h0002, 16'h0, 3'd0, 6'b111110, 8'h00, 8'h05, 0, 0, 0, 8'h04);
        issue(1, BEQ, 16'h0001, 16'h0002, 16'h0, 3'd0, 6'b111110, 8'h00, 8'h05, 0, 0, 0, 8'h06);
        issue(1, BEQ, 16'h0007, 16'h0007, 16'h0, 3'd0, 6'd5,      8'h00, 8'h10, 0, 0, 0, 8'h16);
        issue(1, J,   16'h0, 16'h0, 16'h0, 3'd0, 6'd0, 8'hA0, 8'h10, 1, 0, 0, 8'hA0);

        e_rd = 16'h0002;
        issue(1, ADD,  16'h0001, 16'h0001, 16'h0, 3'd0, 6'd0, 8'h00, 8'hFF, 1, 0, 0, 8'h00);
        e_rd = 16'hFFF0;
        issue(1, ADDI, 16'h0010, 16'h0000, 16'h0, 3'd0, 6'b100000, 8'h00, 8'h00, 1, 0, 0, 8'h01);
        e_rd = 16'h0080;
        issue(1, SLL,  16'h0000, 16'h0001, 16'h0, 3'd7, 6'd0, 8'h00, 8'h01, 1, 0, 0, 8'h02);
        e_rd = 16'h1000;
        issue(1, SRL,  16'h0000, 16'h8000, 16'h0, 3'd3, 6'd0, 8'h00, 8'h02, 1, 0, 0, 8'h03);
        e_rd = 16'h0F0F;
        issue(1, AND_, 16'hFF0F, 16'h0F0F, 16'h0, 3'd0, 6'd0, 8'h00, 8'h03, 1, 0, 0, 8'h04);
        e_rd = 16'h0FF0;
        issue(1, OR_,  16'h00F0, 16'h0F00, 16'h0, 3'd0, 6'd0, 8'h00, 8'h04, 1, 0, 0, 8'h05);
        e_rd = 16'hF0F0;
        issue(1, XOR_, 16'hFFFF, 16'h0F0F, 16'h0, 3'd0, 6'd0, 8'h00, 8'h05, 1, 0, 0, 8'h06);
        e_rd = 16'h0001;
        issue(1, SLT,  16'hFFFF, 16'h0001, 16'h0, 3'd0, 6'd0, 8'h00, 8'h06, 1, 0, 0, 8'h07);
        e_rd = 16'h0000;
        issue(1, SLT,  16'h0001, 16'hFFFF, 16'h0, 3'd0, 6'd0, 8'h00, 8'h07, 1, 0, 0, 8'h08);
        // 0x30 must still hold 0x5555: the disabled SW and the non-SW store are ignored.
        e_rd = 16'h5555;
        issue(1, LW,   16'h0, 16'h0, 16'h0, 3'd0, 6'd0, 8'h30, 8'h08, 1, 1, 0, 8'h09);

        e_rd = 16'h0; e_hi = 16'h0; e_lo = 16'h0; e_tmp = 32'h0;
        issue(0, SW,   16'h0, 16'h0, 16'hDEAD, 3'd0, 6'd0, 8'h30, 8'h09, 1, 0, 1, 8'h00);
        e_rd = 16'h5555;
        issue(1, LW,   16'h0, 16'h0, 16'h0, 3'd0, 6'd0, 8'h30, 8'h00, 1, 1, 0, 8'h01);

        check_en = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
